// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S master transmitter.
// Default widths, the stereo sample bundle and the slot side encoding.
package i2s_pkg;

  localparam int I2S_DATA_W = 16;
  localparam int I2S_SLOT_W = 32;

  typedef struct packed {
    logic [I2S_DATA_W-1:0] left;
    logic [I2S_DATA_W-1:0] right;
  } stereo_sample_t;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } i2s_side_e;

endpackage

// File: rtl/i2s_master_tx_if.sv
// Sample-pair valid/ready handshake into the I2S transmitter.
// master = sample source, slave = transmitter.
interface i2s_master_tx_if
  import i2s_pkg::*;
#(
  parameter int DATA_W = I2S_DATA_W
) ();

  logic [DATA_W-1:0] TX_LDATA;
  logic [DATA_W-1:0] TX_RDATA;
  logic              TX_VALID;
  logic              TX_READY;

  modport master (
    output TX_LDATA,
    output TX_RDATA,
    output TX_VALID,
    input  TX_READY
  );

  modport slave (
    input  TX_LDATA,
    input  TX_RDATA,
    input  TX_VALID,
    output TX_READY
  );

endinterface

// File: rtl/i2s_clk_gen.sv
// BCLK/WCLK generation from MCLK with bit position tracking.
// slot_k/slot_side describe the position entered on this fall event.
module i2s_clk_gen
  import i2s_pkg::*;
#(
  parameter int  SLOT_W   = I2S_SLOT_W,
  parameter int  BCLK_DIV = 2,
  localparam int KW       = $clog2(SLOT_W)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          bclk,
  output logic          wclk,
  output logic          fall_evt,
  output logic          frame_start,
  output logic [KW-1:0] slot_k,
  output i2s_side_e     slot_side
);

  localparam int BW = $clog2(2 * SLOT_W);
  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [DW-1:0] div_q, div_d;
  logic [BW-1:0] bit_q, bit_d;
  logic          bclk_q, bclk_d;
  logic          wclk_q, wclk_d;
  logic          half_end;

  // Divider, bit counter and the next word-clock level.
  always_comb begin
    half_end    = (div_q == DW'(BCLK_DIV - 1));
    div_d       = half_end ? '0 : div_q + 1'b1;
    bclk_d      = half_end ? ~bclk_q : bclk_q;
    fall_evt    = half_end & bclk_q;
    frame_start = fall_evt & (bit_q == BW'(2 * SLOT_W - 1));
    bit_d       = bit_q;
    if (fall_evt) begin
      bit_d = frame_start ? '0 : bit_q + 1'b1;
    end
    wclk_d    = (bit_d >= BW'(SLOT_W));
    slot_side = i2s_side_e'(wclk_d);
    slot_k    = wclk_d ? KW'(bit_d - BW'(SLOT_W)) : KW'(bit_d);
  end

  // Clock generator state; reset parks just before a frame wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      bit_q  <= BW'(2 * SLOT_W - 1);
      bclk_q <= 1'b0;
      wclk_q <= 1'b1;
    end else begin
      div_q  <= div_d;
      bit_q  <= bit_d;
      bclk_q <= bclk_d;
      wclk_q <= wclk_d;
    end
  end

  assign bclk = bclk_q;
  assign wclk = wclk_q;

endmodule

// File: rtl/i2s_master_tx.sv
// I2S master transmitter: holding/shadow sample registers and serialiser.
// Build macro I2S_TX_UNDERRUN_ZERO_EN: underrun sends silence instead of repeating.
module i2s_master_tx
  import i2s_pkg::*;
#(
  parameter int DATA_W   = I2S_DATA_W,
  parameter int SLOT_W   = I2S_SLOT_W,
  parameter int BCLK_DIV = 2
) (
  input  logic               AUDIO_MCLK,
  input  logic               RESET,
  i2s_master_tx_if.slave     tx,
  input  logic               CLR_UNDERRUN,
  output logic               AUDIO_BCLK,
  output logic               AUDIO_WCLK,
  output logic               SDATA_OUT,
  output logic               SAMPLE_TR,
  output logic               UNDERRUN
);

  localparam int KW = $clog2(SLOT_W);

  typedef struct packed {
    logic [DATA_W-1:0] left;
    logic [DATA_W-1:0] right;
  } pair_t;

  logic          fall_evt;
  logic          frame_start;
  logic [KW-1:0] slot_k;
  i2s_side_e     slot_side;

  pair_t             hold_q, hold_d;
  pair_t             shadow_q, shadow_d;
  pair_t             in_pair;
  logic              hold_full_q, hold_full_d;
  logic              und_q, und_d;
  logic              sdata_q, sdata_d;
  logic              tr_q, tr_d;
  logic              accept;
  logic [DATA_W-1:0] word;
  logic [DATA_W-1:0] shifted;

  i2s_clk_gen #(
    .SLOT_W   (SLOT_W),
    .BCLK_DIV (BCLK_DIV)
  ) u_clk_gen (
    .clk         (AUDIO_MCLK),
    .rst         (RESET),
    .bclk        (AUDIO_BCLK),
    .wclk        (AUDIO_WCLK),
    .fall_evt    (fall_evt),
    .frame_start (frame_start),
    .slot_k      (slot_k),
    .slot_side   (slot_side)
  );

  // Handshake, frame load, underrun flag and next serial bit.
  always_comb begin
    in_pair     = {tx.TX_LDATA, tx.TX_RDATA};
    accept      = tx.TX_VALID & ~hold_full_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shadow_d    = shadow_q;
    und_d       = und_q & ~CLR_UNDERRUN;
    tr_d        = frame_start;
    sdata_d     = sdata_q;
    if (frame_start) begin
      if (hold_full_q) begin
        shadow_d    = hold_q;
        hold_full_d = 1'b0;
      end else if (accept) begin
        shadow_d = in_pair;
      end else begin
        und_d = 1'b1;
`ifdef I2S_TX_UNDERRUN_ZERO_EN
        shadow_d = '0;
`else
        shadow_d = shadow_q;
`endif
      end
    end else if (accept) begin
      hold_d      = in_pair;
      hold_full_d = 1'b1;
    end
    word    = (slot_side == RIGHT) ? shadow_q.right : shadow_q.left;
    shifted = word << (slot_k - KW'(1));
    if (fall_evt) begin
      sdata_d = ((slot_k != '0) && (slot_k <= KW'(DATA_W)))
              ? shifted[DATA_W-1] : 1'b0;
    end
  end

  // Sample registers and registered serial outputs.
  always_ff @(posedge AUDIO_MCLK or posedge RESET) begin
    if (RESET) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shadow_q    <= '0;
      und_q       <= 1'b0;
      sdata_q     <= 1'b0;
      tr_q        <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shadow_q    <= shadow_d;
      und_q       <= und_d;
      sdata_q     <= sdata_d;
      tr_q        <= tr_d;
    end
  end

  assign tx.TX_READY = ~hold_full_q;
  assign SDATA_OUT   = sdata_q;
  assign SAMPLE_TR   = tr_q;
  assign UNDERRUN    = und_q;

endmodule

// File: tb/tb_i2s_master_tx.sv
// Self-checking bench for i2s_master_tx.
// Frame-level reference model plus an I2S line deserialiser.
module tb_i2s_master_tx;
  import i2s_pkg::*;

  localparam int BD  = 2;
  localparam int SW  = I2S_SLOT_W;
  localparam int DW  = I2S_DATA_W;
  localparam int BP  = 2 * BD;
  localparam int FR  = 2 * SW * BP;
  localparam int FS0 = BP;
  localparam int NV  = 7;
`ifdef I2S_TX_UNDERRUN_ZERO_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic bclk, wclk, sdata, tr, und;

  i2s_master_tx_if #(.DATA_W(DW)) tx_if ();

  i2s_master_tx #(
    .DATA_W   (DW),
    .SLOT_W   (SW),
    .BCLK_DIV (BD)
  ) dut (
    .AUDIO_MCLK   (clk),
    .RESET        (rst),
    .tx           (tx_if.slave),
    .CLR_UNDERRUN (clr),
    .AUDIO_BCLK   (bclk),
    .AUDIO_WCLK   (wclk),
    .SDATA_OUT    (sdata),
    .SAMPLE_TR    (tr),
    .UNDERRUN     (und)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int             m_t;
  logic           m_hold_v;
  stereo_sample_t m_hold;
  stereo_sample_t m_cur;
  logic           m_und;

  logic           d_prev_bclk;
  logic           d_last_w;
  int             d_idx;
  int             d_frame;
  logic           cap_en;
  stereo_sample_t cap [8];

  typedef struct {
    int          offer;
    logic [15:0] l;
    logic [15:0] r;
    int          clr_m;
    logic [15:0] el;
    logic [15:0] er;
    logic        eu;
  } vec_t;
  vec_t tab [NV];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0d)", nm, act, exp_v, m_t);
    end
  endtask

  function automatic logic [5:0] pins();
    return {bclk, wclk, sdata, tr, und, tx_if.TX_READY};
  endfunction

  function automatic int bpos();
    return ((m_t / BP) + 2 * SW - 1) % (2 * SW);
  endfunction

  function automatic logic [5:0] exp_vec();
    int          b;
    int          k;
    logic        w;
    logic        bc;
    logic        sd;
    logic        ft;
    logic [15:0] wd;
    logic [15:0] sh;
    b  = bpos();
    k  = b % SW;
    w  = (b >= SW);
    bc = (((m_t / BD) % 2) == 1);
    ft = (m_t >= FS0) && (((m_t - FS0) % FR) == 0);
    wd = w ? m_cur.right : m_cur.left;
    sh = wd >> (DW - k);
    sd = (k >= 1 && k <= DW) ? sh[0] : 1'b0;
    return {bc, w, sd, ft, m_und, !m_hold_v};
  endfunction

  task automatic model_reset();
    m_t         = 0;
    m_hold_v    = 1'b0;
    m_hold      = '0;
    m_cur       = '0;
    m_und       = 1'b0;
    d_prev_bclk = 1'b0;
    d_last_w    = 1'b1;
    d_idx       = 0;
    d_frame     = -1;
  endtask

  task automatic model_edge();
    logic           off;
    logic           fs;
    stereo_sample_t inp;
    inp = {tx_if.TX_LDATA, tx_if.TX_RDATA};
    off = tx_if.TX_VALID && !m_hold_v;
    m_t++;
    fs = (m_t >= FS0) && (((m_t - FS0) % FR) == 0);
    if (clr) m_und = 1'b0;
    if (fs) begin
      if (m_hold_v) begin
        m_cur    = m_hold;
        m_hold_v = 1'b0;
      end else if (off) begin
        m_cur = inp;
      end else begin
        m_und = 1'b1;
        if (ZERO) m_cur = '0;
      end
    end else if (off) begin
      m_hold   = inp;
      m_hold_v = 1'b1;
    end
  endtask

  task automatic deser();
    if (bclk && !d_prev_bclk) begin
      if (wclk !== d_last_w) d_idx = 0;
      else d_idx++;
      if (!wclk && d_last_w) d_frame++;
      d_last_w = wclk;
      if (d_idx >= 1 && d_idx <= DW) begin
        if (cap_en && d_frame >= 0 && d_frame < 8) begin
          if (wclk) cap[d_frame].right[DW-d_idx] = sdata;
          else cap[d_frame].left[DW-d_idx] = sdata;
        end
      end else begin
        check("pad_bit", 32'(sdata), 32'(0));
      end
    end
    d_prev_bclk = bclk;
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_edge();
    @(negedge clk);
    if (!rst) begin
      check("pins", 32'(pins()), 32'(exp_vec()));
      deser();
    end
  endtask

  task automatic run_to(input int tt);
    while (m_t < tt) step();
  endtask

  initial begin
    int ts;
    int first;
    int second;
    logic [15:0] rl;
    logic [15:0] rr;
    rl = ZERO ? 16'h0000 : 16'h1234;
    rr = ZERO ? 16'h0000 : 16'h8000;
    tab[0] = '{1, 16'hA5C3, 16'h7FFF, 0, 16'hA5C3, 16'h7FFF, 1'b0};
    tab[1] = '{1, 16'h1234, 16'h8000, 0, 16'h1234, 16'h8000, 1'b0};
    tab[2] = '{0, 16'h0000, 16'h0000, 0, rl, rr, 1'b1};
    tab[3] = '{1, 16'hABCD, 16'h0001, 1, 16'hABCD, 16'h0001, 1'b0};
    tab[4] = '{0, 16'h0000, 16'h0000, 2,
               ZERO ? 16'h0000 : 16'hABCD,
               ZERO ? 16'h0000 : 16'h0001, 1'b1};
    tab[5] = '{2, 16'h5A5A, 16'hC3C3, 1, 16'h5A5A, 16'hC3C3, 1'b0};
    tab[6] = '{1, 16'hFFFF, 16'h8001, 0, 16'hFFFF, 16'h8001, 1'b0};

    tx_if.TX_VALID = 1'b0;
    tx_if.TX_LDATA = '0;
    tx_if.TX_RDATA = '0;
    cap_en = 1'b1;
    for (int i = 0; i < 8; i++) cap[i] = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_pins", 32'(pins()), 32'(6'b010001));
    rst = 1'b0;
    model_reset();

    for (int i = 0; i < NV; i++) begin
      ts = FS0 + FR * i;
      if (tab[i].clr_m == 1) begin
        run_to(ts - 101);
        clr = 1'b1;
        step();
        clr = 1'b0;
      end
      if (tab[i].offer == 1) begin
        run_to(ts - 4);
        tx_if.TX_VALID = 1'b1;
        tx_if.TX_LDATA = tab[i].l;
        tx_if.TX_RDATA = tab[i].r;
        step();
        tx_if.TX_VALID = 1'b0;
      end
      run_to(ts - 1);
      if (tab[i].offer == 2) begin
        tx_if.TX_VALID = 1'b1;
        tx_if.TX_LDATA = tab[i].l;
        tx_if.TX_RDATA = tab[i].r;
      end
      if (tab[i].clr_m == 2) clr = 1'b1;
      step();
      tx_if.TX_VALID = 1'b0;
      clr = 1'b0;
      check("load_underrun", 32'(und), 32'(tab[i].eu));
      check("load_tr", 32'(tr), 32'(1));
      check("load_ready", 32'(tx_if.TX_READY), 32'(1));
    end
    run_to(FS0 + FR * NV + 2 * BP);
    for (int i = 0; i < NV; i++) begin
      check("frame_left", 32'(cap[i].left), 32'(tab[i].el));
      check("frame_right", 32'(cap[i].right), 32'(tab[i].er));
    end

    for (int n = 0; n < FR && bpos() != 40; n++) step();
    check("bit_40", 32'(bpos()), 32'(40));
    tx_if.TX_VALID = 1'b1;
    #2;
    rst = 1'b1;
    tx_if.TX_VALID = 1'b0;
    #1;
    check("async_reset", 32'(pins()), 32'(6'b010001));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cap_en = 1'b0;

    first = -1;
    for (int n = 0; n < 300 && first < 0; n++) begin
      step();
      if (tr) first = m_t;
    end
    check("first_tr", 32'(first), 32'(FS0));
    second = -1;
    for (int n = 0; n < 300 && second < 0; n++) begin
      step();
      if (tr) second = m_t;
    end
    check("tr_period", 32'(second - first), 32'(FR));

    for (int n = 0; n < 20 * FR; n++) begin
      tx_if.TX_VALID = ($urandom % 6) == 0;
      tx_if.TX_LDATA = 16'($urandom);
      tx_if.TX_RDATA = 16'($urandom);
      clr = ($urandom % 50) == 0;
      step();
    end
    tx_if.TX_VALID = 1'b0;
    clr = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2s_master_tx.md
# i2s_master_tx

I2S master transmitter for the audio codec path. Generates AUDIO_BCLK and AUDIO_WCLK from AUDIO_MCLK and serialises one 16-bit stereo sample pair per frame onto SDATA_OUT. It is the driving end for the existing I2S line-in deserialiser, which samples the same bit positions. Samples arrive through a one-deep valid/ready holding register; a shadow register isolates the frame being shifted.

## Interface
- DATA_W, 16: sample width per channel.
- SLOT_W, 32: BCLK periods per channel slot; must be ≥ DATA_W+1.
- BCLK_DIV, 2: MCLK cycles per BCLK half-period; must be ≥ 1.
- AUDIO_MCLK  in  1  sole clock; all logic on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- TX_LDATA  in  DATA_W  left sample, two's complement.
- TX_RDATA  in  DATA_W  right sample.
- TX_VALID  in  1  sample pair offered.
- TX_READY  out  1  holding register empty.
- CLR_UNDERRUN  in  1  clears UNDERRUN.
- AUDIO_BCLK  out  1  bit clock.
- AUDIO_WCLK  out  1  word clock; 0 = left slot, 1 = right slot.
- SDATA_OUT  out  1  serial data.
- SAMPLE_TR  out  1  one-cycle pulse at the start of each frame (WCLK 1→0).
- UNDERRUN  out  1  sticky; a frame started with no sample available.

## Operation
- Divider DIV_CNT counts 0..BCLK_DIV-1. BCLK toggles when DIV_CNT = BCLK_DIV-1.
- A BCLK fall event is the cycle in which BCLK is driven 1→0.
- BIT_CNT spans 0..2·SLOT_W-1. It increments on each fall event and wraps.
- WCLK = (BIT_CNT ≥ SLOT_W). Slot position k = BIT_CNT mod SLOT_W.
- SDATA_OUT at k = 1..DATA_W carries word bit DATA_W-k, MSB first. It is 0 for k = 0 and k > DATA_W (standard I2S one-bit delay).
- BCLK, WCLK and SDATA_OUT are registered and all change on the same fall event. Data is stable across the BCLK rising edge.
- Frame load happens on the fall event where BIT_CNT wraps to 0:
  - Holding full: shadow ← holding, holding → empty.
  - Holding empty: underrun. UNDERRUN ← 1 and the shadow is refilled per Configuration.
  - A TX_VALID & TX_READY accept in the same cycle bypasses directly into the shadow. This is not an underrun, and the holding register stays empty.
- Handshake:
  - TX_READY = holding empty.
  - Data is accepted on TX_VALID & TX_READY.
  - TX_READY never depends combinationally on TX_VALID.
- UNDERRUN behaviour:
  - Set has priority over CLR_UNDERRUN in the same cycle.
  - CLR_UNDERRUN has no other effect.
- Reset values:
  - Outputs: BCLK 0, WCLK 1, SDATA_OUT 0, SAMPLE_TR 0, UNDERRUN 0, TX_READY 1.
  - Internal state: holding empty, shadow 0, DIV_CNT 0, BIT_CNT 2·SLOT_W-1.
- Reset mid-frame aborts immediately to the reset state. No partial word is completed.

## Timing
- Fall events:
  - The first fall event after reset release occurs 2·BCLK_DIV cycles after release, i.e. on the cycle at the end of the second half-period.
  - That event wraps BIT_CNT to 0, drives WCLK 1→0, pulses SAMPLE_TR and performs the first frame load.
- Periods:
  - BCLK period = 2·BCLK_DIV MCLK cycles.
  - Frame = 4·SLOT_W·BCLK_DIV MCLK cycles; 256 with defaults (48 kHz at 12.288 MHz).
- SAMPLE_TR is high for exactly one MCLK cycle per frame, coincident with the WCLK fall.
- Left MSB appears one BCLK period after the frame start. Right MSB appears one BCLK period after WCLK rises.
- Latency from a handshake to the left MSB: up to one frame plus one BCLK period.
- TX_READY reasserts on the cycle after the frame load that empties the holding register.

## Configuration
- I2S_TX_UNDERRUN_ZERO_EN defined: on underrun the shadow is loaded with 0 on both channels (silence).
- Not defined: on underrun the shadow keeps its previous contents, so the last sample pair repeats.
- UNDERRUN flagging is identical in both builds.

## Structure
- Package i2s_pkg holds:
  - constants I2S_DATA_W = 16 and I2S_SLOT_W = 32;
  - typedef stereo_sample_t {left, right};
  - enum i2s_side_e {LEFT, RIGHT}.
- Sub-module i2s_clk_gen:
  - contains DIV_CNT, BIT_CNT, BCLK and WCLK;
  - outputs fall_evt, frame_start and slot position k.
- The top level contains the holding/shadow registers, shifter and UNDERRUN flag.

## Test plan
- Reset then free-run with defaults:
  - BCLK period 4 cycles;
  - WCLK low 128 / high 128 cycles;
  - SAMPLE_TR pulse every 256 cycles;
  - first pulse 4 cycles after release.
- Offer L=0xA5C3, R=0x7FFF before the first frame:
  - a bench deserialiser sampling on BCLK rise at k = 1..16 recovers exactly those values;
  - bit k = 0 and k = 17..31 read 0.
- Hold TX_VALID low across a frame start:
  - UNDERRUN rises on that frame-start cycle;
  - SDATA carries 0x0000 with the macro defined, and repeats the prior pair 0x1234/0x8000 without it.
- Present TX_VALID exactly on the frame-load cycle with the holding register empty: the data is sent in that frame, UNDERRUN stays 0, and TX_READY stays 1.
- Pulse CLR_UNDERRUN coincident with a new underrun: UNDERRUN stays 1. A later CLR_UNDERRUN with no underrun clears it.
- Assert RESET at BIT_CNT = 40:
  - BCLK, SDATA_OUT = 0, WCLK = 1 and TX_READY = 1 within that same cycle (asynchronous);
  - after release, timing restarts as in the first scenario.
